// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester sequencer for the shared ripple ALU.
// Optional build macro ALU_ARB_OPCHECK_EN: opcodes 4, 5 and 7 are answered
// with rsp_err=1 on the edge after accept, without being driven onto the ALU.
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_out,
    output logic        rsp_zero,
    output logic        rsp_over,
    output logic        rsp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_over,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        last_q;
    logic        gnt0, gnt1, acc;
    logic [31:0] a_d, b_d;
    logic [2:0]  op_d;
`ifdef ALU_ARB_OPCHECK_EN
    logic        err_q, rsp_err_q, illegal_d;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif
    // grant favours the requester not served last when both are valid
    always_comb begin
        gnt0       = req0_valid & (~req1_valid | last_q);
        gnt1       = req1_valid & (~req0_valid | ~last_q);
        req0_ready = (state_q == IDLE) & gnt0 & rst_n;
        req1_ready = (state_q == IDLE) & gnt1 & rst_n;
        acc        = (req0_ready & req0_valid) | (req1_ready & req1_valid);
        a_d        = gnt1 ? req1_a : req0_a;
        b_d        = gnt1 ? req1_b : req0_b;
        op_d       = gnt1 ? req1_op : req0_op;
        busy       = state_q != IDLE;
`ifdef ALU_ARB_OPCHECK_EN
        illegal_d  = (op_d == 3'd4) | (op_d == 3'd5) | (op_d == 3'd7);
`endif
    end
    // sequencer: accept, wait for the ripple to settle, hold response until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            last_q    <= 1'b1;
            alu_a     <= 32'd0;
            alu_b     <= 32'd0;
            alu_op    <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= 32'd0;
            rsp_zero  <= 1'b0;
            rsp_over  <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (acc) begin
                    rsp_id  <= gnt1;
                    last_q  <= gnt1;
                    state_q <= WAIT;
`ifdef ALU_ARB_OPCHECK_EN
                    err_q   <= illegal_d;
                    cnt_q   <= illegal_d ? 8'd1 : 8'(SETTLE_CYCLES);
                    if (!illegal_d) begin
                        alu_a  <= a_d;
                        alu_b  <= b_d;
                        alu_op <= op_d;
                    end
`else
                    cnt_q   <= 8'(SETTLE_CYCLES);
                    alu_a   <= a_d;
                    alu_b   <= b_d;
                    alu_op  <= op_d;
`endif
                end
                WAIT: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q   <= RESP;
                        rsp_valid <= 1'b1;
`ifdef ALU_ARB_OPCHECK_EN
                        rsp_out   <= err_q ? 32'd0 : alu_out;
                        rsp_zero  <= ~err_q & alu_zero;
                        rsp_over  <= ~err_q & alu_over;
                        rsp_err_q <= err_q;
`else
                        rsp_out   <= alu_out;
                        rsp_zero  <= alu_zero;
                        rsp_over  <= alu_over;
`endif
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU stub.
module tb_alu_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_over, rsp_err, busy;
    logic [31:0] rsp_out, alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_over;
    int total = 0, bad = 0, cyc = 0;

    typedef struct {logic id; logic [31:0] out; logic zero; logic over; logic err; int lat;} exp_t;
    exp_t q[$];

    alu_arbiter #(.SETTLE_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_zero(rsp_zero), .rsp_over(rsp_over), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_over(alu_over), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stub: and/or/add/slt/sub, xor for the remaining opcodes
    logic [31:0] sum, dif;
    always_comb begin
        sum      = alu_a + alu_b;
        dif      = alu_a - alu_b;
        alu_over = 1'b0;
        case (alu_op)
            3'd0: alu_out = alu_a & alu_b;
            3'd1: alu_out = alu_a | alu_b;
            3'd2: begin alu_out = sum; alu_over = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]); end
            3'd3: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'd6: begin alu_out = dif; alu_over = (alu_a[31] != alu_b[31]) && (dif[31] != alu_a[31]); end
            default: alu_out = alu_a ^ alu_b;
        endcase
        alu_zero = alu_out == 32'd0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic id, input logic [31:0] out, input logic zero, over, err, input int lat);
        exp_t e;
        e.id = id; e.out = out; e.zero = zero; e.over = over; e.err = err; e.lat = lat;
        return e;
    endfunction

    // monitor: latency from accept, in-order response compare, ready exclusivity
    int  acc_edge = 0;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (rst_n) chk("ready_excl", {63'd0, req0_ready & req1_ready}, 64'd0);
        if (rsp_valid && !prev_v) begin
            if (q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
            else chk("latency", 64'(cyc - acc_edge), 64'(q[0].lat));
        end
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) chk("unexpected_pop", 64'd1, 64'd0);
            else begin
                chk("rsp_id", {63'd0, rsp_id}, {63'd0, q[0].id});
                chk("rsp_out", {32'd0, rsp_out}, {32'd0, q[0].out});
                chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, q[0].zero});
                chk("rsp_over", {63'd0, rsp_over}, {63'd0, q[0].over});
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, q[0].err});
                void'(q.pop_front());
            end
        end
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_edge = cyc + 1;
        prev_v = rsp_valid;
    end

    task automatic set_req(input logic id, input logic v, input logic [31:0] a, b, input logic [2:0] op);
        if (id) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
        else begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
    endtask

    // returns just after the accept edge with the request withdrawn
    task automatic issue(input logic id, input logic [31:0] a, b, input logic [2:0] op, input exp_t e);
        int n = 0;
        q.push_back(e);
        set_req(id, 1'b1, a, b, op);
        do begin @(negedge clk); n++; end while (!(id ? req1_ready : req0_ready) && n < 100);
        chk("accept", {63'd0, id ? req1_ready : req0_ready}, 64'd1);
        @(posedge clk); #1;
        set_req(id, 1'b0, a, b, op);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic wait_stable(input logic [31:0] a, b, input logic [2:0] op);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            chk("wait_alu_stable", {29'd0, alu_a, alu_op}, {29'd0, a, op});
            chk("wait_alu_b", {32'd0, alu_b}, {32'd0, b});
        end
    endtask

    initial begin
        int n, prev;
        logic [35:0] snap;
        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rsp", {25'd0, rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_over, rsp_err}, 64'd0);
        chk("rst_alu", {29'd0, alu_a, alu_op}, 64'd0);
        chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
        chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // single add
        issue(1'b0, 32'd5, 32'd7, 3'd2, mk(1'b0, 32'd12, 1'b0, 1'b0, 1'b0, 16));
        @(negedge clk);
        chk("add_busy", {63'd0, busy}, 64'd1);
        chk("add_alu", {29'd0, alu_a, alu_op}, {29'd0, 32'd5, 3'd2});
        chk("add_alu_b", {32'd0, alu_b}, 64'd7);
        drain();

        // tie-breaking from reset: 0,1,0,1 at 18-cycle spacing
        do_reset();
        set_req(1'b0, 1'b1, 32'd1, 32'd2, 3'd2);
        set_req(1'b1, 1'b1, 32'd10, 32'd3, 3'd6);
        for (int k = 0; k < 4; k++) q.push_back(mk(k[0], k[0] ? 32'd7 : 32'd3, 1'b0, 1'b0, 1'b0, 16));
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!(req0_ready || req1_ready) && n < 100);
            chk("tie_id", {63'd0, req1_ready}, {63'd0, k[0]});
            if (k > 0) chk("tie_spacing", 64'(cyc + 1 - prev), 64'd18);
            prev = cyc + 1;
        end
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'd0);
        drain();

        // backpressure with signed overflow, req0 waiting behind it
        rsp_ready = 1'b0;
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 3'd2, mk(1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 16));
        q.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 16));
        set_req(1'b0, 1'b1, 32'd3, 32'd4, 3'd0);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
        snap = {rsp_id, rsp_out, rsp_zero, rsp_over, rsp_err};
        chk("bp_snap", {28'd0, snap}, {28'd0, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", {27'd0, rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_over, rsp_err}, {27'd0, 1'b1, snap});
            chk("bp_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_early", {63'd0, req0_ready}, 64'd0);
        @(negedge clk);
        chk("bp_next_accept", {63'd0, req0_ready}, 64'd1);
        @(posedge clk); #1 set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        drain();

        // sub and slt with operand stability during WAIT
        issue(1'b0, 32'h1234, 32'h1234, 3'd6, mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 16));
        wait_stable(32'h1234, 32'h1234, 3'd6);
        drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd3, mk(1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 16));
        wait_stable(32'hFFFF_FFFF, 32'd1, 3'd3);
        drain();

        // opcode 5
`ifdef ALU_ARB_OPCHECK_EN
        issue(1'b1, 32'd9, 32'd3, 3'd5, mk(1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1));
        @(negedge clk);
        chk("ill_alu_op", {61'd0, alu_op}, 64'd3);
`else
        issue(1'b1, 32'd9, 32'd3, 3'd5, mk(1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 16));
        @(negedge clk);
        chk("ill_alu_op", {61'd0, alu_op}, 64'd5);
`endif
        drain();

        // reset mid-WAIT with req0 held valid
        set_req(1'b0, 1'b1, 32'd100, 32'd23, 3'd2);
        n = 0;
        do begin @(negedge clk); n++; end while (!req0_ready && n < 100);
        chk("mid_accept", {63'd0, req0_ready}, 64'd1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", {63'd0, req0_ready}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        q.push_back(mk(1'b0, 32'd123, 1'b0, 1'b0, 1'b0, 16));
        @(negedge clk);
        chk("mid_busy", {62'd0, busy, rsp_valid}, 64'd0);
        chk("mid_alu", {29'd0, alu_a, alu_op}, 64'd0);
        chk("mid_alu_b", {32'd0, alu_b}, 64'd0);
        chk("mid_reaccept", {63'd0, req0_ready}, 64'd1);
        @(posedge clk); #1 set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        chk("mid_relaunch", {31'd0, busy, alu_a}, {31'd0, 1'b1, 32'd100});
        drain();
        repeat (40) @(negedge clk);
        chk("final_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
